// File: rtl/forwarding_unit.sv
// EX-stage operand bypass controller: registers ID source IDs into an EX copy,
// steers ALU operands from MEM/WB by combinational compare, counts forward cycles.
module forwarding_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forwarding_mode,
    input  logic             hazard_detected,
    input  logic             flush,
    input  logic [3:0]       id_src_1,
    input  logic [3:0]       id_src_2,
    input  logic             id_two_src,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic [3:0]       wb_dest,
    input  logic             wb_wb_en,
    input  logic             clear_count,
    output logic [3:0]       ex_src_1,
    output logic [3:0]       ex_src_2,
    output logic             ex_two_src,
    output logic             ex_valid,
    output logic [1:0]       sel_src_1,
    output logic [1:0]       sel_src_2,
    output logic [CNT_W-1:0] fwd_count
);

    localparam int unsigned REG_W  = 4;
    localparam logic [REG_W-1:0] PC_REG = 4'hF;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    logic [REG_W-1:0] ex_src_1_q, ex_src_1_d;
    logic [REG_W-1:0] ex_src_2_q, ex_src_2_d;
    logic             ex_two_src_q, ex_two_src_d;
    logic             ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0] fwd_count_q, fwd_count_d;

    // EX capture: flush and stall both insert a bubble
    always_comb begin
        ex_src_1_d   = id_src_1;
        ex_src_2_d   = id_src_2;
        ex_two_src_d = id_two_src;
        ex_valid_d   = 1'b1;
        if (flush || hazard_detected) begin
            ex_src_1_d   = '0;
            ex_src_2_d   = '0;
            ex_two_src_d = 1'b0;
            ex_valid_d   = 1'b0;
        end
    end

    // MEM is the younger producer, so it is checked before WB; PC is never bypassed
    function automatic logic [1:0] pick_sel(
        input logic             enable,
        input logic [REG_W-1:0] src,
        input logic             m_en,
        input logic [REG_W-1:0] m_dest,
        input logic             w_en,
        input logic [REG_W-1:0] w_dest
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (enable && (src != PC_REG)) begin
            if (m_en && (m_dest == src)) begin
                sel = SEL_MEM;
            end else if (w_en && (w_dest == src)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        sel_src_1 = pick_sel(forwarding_mode && ex_valid_q, ex_src_1_q,
                             mem_wb_en, mem_dest, wb_wb_en, wb_dest);
        sel_src_2 = pick_sel(forwarding_mode && ex_valid_q && ex_two_src_q, ex_src_2_q,
                             mem_wb_en, mem_dest, wb_wb_en, wb_dest);
    end

    // Saturating forward-event counter; clear wins over a same-cycle event
    always_comb begin
        fwd_count_d = fwd_count_q;
        if (clear_count) begin
            fwd_count_d = '0;
        end else if (((sel_src_1 != SEL_RF) || (sel_src_2 != SEL_RF)) && (fwd_count_q != '1)) begin
            fwd_count_d = fwd_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_src_1_q   <= '0;
            ex_src_2_q   <= '0;
            ex_two_src_q <= 1'b0;
            ex_valid_q   <= 1'b0;
            fwd_count_q  <= '0;
        end else begin
            ex_src_1_q   <= ex_src_1_d;
            ex_src_2_q   <= ex_src_2_d;
            ex_two_src_q <= ex_two_src_d;
            ex_valid_q   <= ex_valid_d;
            fwd_count_q  <= fwd_count_d;
        end
    end

    assign ex_src_1   = ex_src_1_q;
    assign ex_src_2   = ex_src_2_q;
    assign ex_two_src = ex_two_src_q;
    assign ex_valid   = ex_valid_q;
    assign fwd_count  = fwd_count_q;

endmodule

// File: tb/tb_forwarding_unit.sv
// Scoreboard bench for forwarding_unit: driver pushes model predictions, monitor
// pops and compares them against the DUT every cycle.
module tb_forwarding_unit;

    localparam int unsigned CNT_W   = 10;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             forwarding_mode = 1'b0;
    logic             hazard_detected = 1'b0;
    logic             flush = 1'b0;
    logic [3:0]       id_src_1 = '0;
    logic [3:0]       id_src_2 = '0;
    logic             id_two_src = 1'b0;
    logic [3:0]       mem_dest = '0;
    logic             mem_wb_en = 1'b0;
    logic [3:0]       wb_dest = '0;
    logic             wb_wb_en = 1'b0;
    logic             clear_count = 1'b0;
    logic [3:0]       ex_src_1;
    logic [3:0]       ex_src_2;
    logic             ex_two_src;
    logic             ex_valid;
    logic [1:0]       sel_src_1;
    logic [1:0]       sel_src_2;
    logic [CNT_W-1:0] fwd_count;

    forwarding_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .forwarding_mode(forwarding_mode),
        .hazard_detected(hazard_detected), .flush(flush),
        .id_src_1(id_src_1), .id_src_2(id_src_2), .id_two_src(id_two_src),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .clear_count(clear_count),
        .ex_src_1(ex_src_1), .ex_src_2(ex_src_2), .ex_two_src(ex_two_src),
        .ex_valid(ex_valid), .sel_src_1(sel_src_1), .sel_src_2(sel_src_2),
        .fwd_count(fwd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s1, s2, two, valid, sel1, sel2, cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_step = 0;
    bit   drv_done = 1'b0;

    // Reference model state: what the EX slot holds and the event count
    int m_s1 = 0, m_s2 = 0, m_two = 0, m_valid = 0, m_cnt = 0;

    function automatic int ref_sel(int valid, int mode, int src, int used,
                                   int men, int mdst, int wen, int wdst);
        if (mode == 0 || valid == 0 || used == 0 || src == 15) return 0;
        if (men != 0 && mdst == src) return 1;
        if (wen != 0 && wdst == src) return 2;
        return 0;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.s1 = m_s1; e.s2 = m_s2; e.two = m_two; e.valid = m_valid; e.cnt = m_cnt;
        e.sel1 = ref_sel(m_valid, int'(forwarding_mode), m_s1, 1,
                         int'(mem_wb_en), int'(mem_dest), int'(wb_wb_en), int'(wb_dest));
        e.sel2 = ref_sel(m_valid, int'(forwarding_mode), m_s2, m_two,
                         int'(mem_wb_en), int'(mem_dest), int'(wb_wb_en), int'(wb_dest));
        return e;
    endfunction

    // One cycle: inputs already applied at the negedge; predict, cross the edge, advance model
    task automatic step();
        exp_t e;
        #1;
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_two = 0; m_valid = 0; m_cnt = 0;
        end
        e = predict();
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            if (clear_count) m_cnt = 0;
            else if ((e.sel1 != 0 || e.sel2 != 0) && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (flush || hazard_detected) begin
                m_s1 = 0; m_s2 = 0; m_two = 0; m_valid = 0;
            end else begin
                m_s1 = int'(id_src_1); m_s2 = int'(id_src_2);
                m_two = int'(id_two_src); m_valid = 1;
            end
        end
        @(negedge clk);
        n_step++;
    endtask

    task automatic set_id(input logic [3:0] a, input logic [3:0] b, input logic two);
        id_src_1 = a; id_src_2 = b; id_two_src = two;
    endtask

    task automatic set_fw(input logic [3:0] md, input logic me, input logic [3:0] wd, input logic we);
        mem_dest = md; mem_wb_en = me; wb_dest = wd; wb_wb_en = we;
    endtask

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d, expected %0d", nm, n_step, act, want);
        end
    endtask

    // Monitor: outputs are always presented, so one prediction is consumed every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ex_src_1",   int'(ex_src_1),   e.s1);
                chk("ex_src_2",   int'(ex_src_2),   e.s2);
                chk("ex_two_src", int'(ex_two_src), e.two);
                chk("ex_valid",   int'(ex_valid),   e.valid);
                chk("sel_src_1",  int'(sel_src_1),  e.sel1);
                chk("sel_src_2",  int'(sel_src_2),  e.sel2);
                chk("fwd_count",  int'(fwd_count),  e.cnt);
            end
        end
    end

    function automatic logic [3:0] rnd_reg();
        if ($urandom_range(0, 9) == 0) return 4'hF;
        return 4'($urandom_range(0, 3));
    endfunction

    initial begin
        @(negedge clk);
        // Reset state
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;

        // Basic MEM forward of src1, single-operand instruction
        forwarding_mode = 1'b1;
        set_id(4'd3, 4'd0, 1'b0);
        set_fw(4'd3, 1'b1, 4'd0, 1'b0);
        step(); step(); step();

        // MEM priority over WB on both operands, then WB alone
        set_id(4'd5, 4'd5, 1'b1);
        set_fw(4'd5, 1'b1, 4'd5, 1'b1);
        step(); step();
        mem_wb_en = 1'b0;
        step();

        // Second operand unused; PC never forwarded
        set_id(4'd15, 4'd7, 1'b0);
        set_fw(4'd15, 1'b1, 4'd7, 1'b1);
        step(); step();

        // Stall bubble then capture
        set_id(4'd2, 4'd0, 1'b1);
        set_fw(4'd0, 1'b1, 4'd2, 1'b1);
        hazard_detected = 1'b1;
        step(); step();
        hazard_detected = 1'b0;
        step(); step();

        // Flush together with hazard: single bubble
        flush = 1'b1; hazard_detected = 1'b1;
        step();
        flush = 1'b0; hazard_detected = 1'b0;
        step(); step();

        // Bypass disabled, then re-enabled without a new capture
        set_id(4'd4, 4'd1, 1'b1);
        set_fw(4'd4, 1'b1, 4'd1, 1'b1);
        step();
        forwarding_mode = 1'b0;
        step(); step();
        forwarding_mode = 1'b1;
        step();

        // Saturation and hold, then clear racing a forward event
        for (int i = 0; i < CNT_MAX + 20; i++) step();
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        step(); step();

        // Asynchronous reset mid-run, then normal capture
        rst = 1'b0;
        step();
        rst = 1'b1;
        step(); step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            forwarding_mode = ($urandom_range(0, 9) != 0);
            hazard_detected = ($urandom_range(0, 7) == 0);
            flush           = ($urandom_range(0, 11) == 0);
            clear_count     = ($urandom_range(0, 49) == 0);
            set_id(rnd_reg(), rnd_reg(), 1'($urandom_range(0, 1)));
            set_fw(rnd_reg(), 1'($urandom_range(0, 1)), rnd_reg(), 1'($urandom_range(0, 1)));
            rst = ($urandom_range(0, 299) != 0);
            step();
            rst = 1'b1;
        end
        clear_count = 1'b0; hazard_detected = 1'b0; flush = 1'b0;
        drv_done = 1'b1;

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/forwarding_unit.md
# forwarding_unit

EX-stage operand bypass controller for the 5-stage ARM pipeline; the counterpart of the stall logic in hazard detection. Hazard detection decides when ID must stall; this block resolves every remaining RAW dependency by steering ALU operands from the MEM or WB stage. It registers the ID-stage source register IDs into an EX-stage copy. It then drives per-operand mux selects combinationally against the current MEM/WB destinations, and keeps a saturating count of forwarding events.

## Interface
Parameters:
- CNT_W, 16, width of forward-event counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- forwarding_mode  in  1  1 = bypass enabled; 0 = all selects forced to 2'b00
- hazard_detected  in  1  stall from hazard detection; EX slot takes a bubble this edge
- flush  in  1  taken branch; EX slot takes a bubble this edge
- id_src_1  in  4  Rn of instruction in ID
- id_src_2  in  4  Rm/Rd of instruction in ID
- id_two_src  in  1  id_src_2 is a real operand
- mem_dest  in  4  destination of instruction in MEM
- mem_wb_en  in  1  MEM instruction writes back
- wb_dest  in  4  destination of instruction in WB
- wb_wb_en  in  1  WB instruction writes back
- clear_count  in  1  synchronous counter clear
- ex_src_1  out  4  registered Rn of EX instruction
- ex_src_2  out  4  registered second source of EX instruction
- ex_two_src  out  1  registered two_src
- ex_valid  out  1  EX slot holds a real instruction
- sel_src_1  out  2  00 regfile, 01 MEM ALU result, 10 WB value
- sel_src_2  out  2  same encoding for second operand
- fwd_count  out  CNT_W  saturating number of cycles with any forward

## Operation
- EX capture register: ex_src_1, ex_src_2, ex_two_src, ex_valid.
  - Priority: flush > hazard_detected > load.
  - flush or hazard_detected at an edge: ex_valid <= 0, ex_src_1/2 <= 0, ex_two_src <= 0.
  - Otherwise: load id_* and set ex_valid <= 1.
- sel_src_1 is combinational:
  - 00 if !forwarding_mode, !ex_valid, or ex_src_1 == 4'hF. R15/PC is never forwarded.
  - Else 01 if mem_wb_en && mem_dest == ex_src_1.
  - Else 10 if wb_wb_en && wb_dest == ex_src_1.
  - Else 00.
- sel_src_2: same rules against ex_src_2, and additionally requires ex_two_src = 1, otherwise 00.
- MEM match always wins over WB match, because it is the younger producer.
- Selects value 11 is never driven.
- fwd_count:
  - Each edge, if clear_count: fwd_count <= 0.
  - Else if (sel_src_1 != 0 || sel_src_2 != 0) and fwd_count != all-ones: increment.
  - At all-ones it holds; no wrap.
- The block never stalls. Load-use cases are stalled by hazard detection upstream and arrive here as a bubble followed by a WB-stage match.

## Timing
- Reset (rst low, asynchronous): ex_src_1 = 0, ex_src_2 = 0, ex_two_src = 0, ex_valid = 0, fwd_count = 0.
  - Consequently sel_src_1 = sel_src_2 = 00 during reset.
- Capture latency: id_* sampled at edge N are visible on ex_* after edge N.
- Select latency: zero cycles from mem_*/wb_*/forwarding_mode changes (pure combinational path).
- Counter increments on the edge that ends the cycle in which a nonzero select was driven; visible the following cycle.
- Reset deassertion mid-stream: first edge after rst rises captures normally. No partial state survives.
- flush and hazard_detected together: single bubble, identical to flush alone.
- clear_count and a forward event in the same cycle: count becomes 0, not 1.

## Test plan
- Reset then load id_src_1=3, id_two_src=0; mem_dest=3, mem_wb_en=1, forwarding_mode=1 -> ex_src_1=3, sel_src_1=01, sel_src_2=00; next cycle fwd_count=1.
- EX src1=5, src2=5, two_src=1; mem_dest=5, mem_wb_en=1; wb_dest=5, wb_wb_en=1 -> both selects 01 (MEM priority). Drop mem_wb_en -> both 10.
- ex_src_2=7 with two_src=0 and wb_dest=7, wb_wb_en=1 -> sel_src_2=00. Also ex_src_1=15 with mem_dest=15, mem_wb_en=1 -> sel_src_1=00.
- hazard_detected=1 for one edge with id_src_1=2 -> ex_valid=0, both selects 00 despite mem_dest=0 match. Next edge with hazard low captures id_src_1=2 -> ex_valid=1.
- forwarding_mode=0 with matching mem_dest -> selects 00 and fwd_count unchanged. Toggle to 1 -> sel 01 in the same cycle, no edge needed.
- Force 65535 forward cycles -> fwd_count=16'hFFFF and holds. Assert clear_count alongside a forward -> 0. Assert rst low mid-run -> all outputs 0 immediately, before the next edge.
